alu_pipe: RTL

Parametrised, handshaked successor to the single-cycle execute ALU. Accepts one operation per cycle through a valid/ready input port, produces a registered WIDTH+1-bit result plus status flags through a valid/ready output port. It adds arithmetic right shift, signed and unsigned compares, and an iterative shift-add multiplier. It sits between the decode/operand-fetch stage and writeback, and tolerates writeback stalls.

---
 rtl/alu_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute ALU with a registered WIDTH+1-bit result,
// status flags, and an iterative shift-add multiplier for MUL.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             error
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_mcand, r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_out_valid;
  logic [WIDTH:0]       r_result;
  logic                 r_zero, r_negative, r_overflow, r_error;

  logic [WIDTH:0]       w_a, w_b, w_sum, w_dif, w_res;
  logic                 w_ovf, w_err, w_is_mul;
  logic [2*WIDTH-1:0]   w_pp, w_acc_nxt;
  logic                 w_mul_done, w_in_ready, w_accept;
  logic                 w_start_mul, w_wr;
  logic [WIDTH:0]       w_wr_res;
  logic                 w_wr_ovf, w_wr_err;

  // Single-cycle datapath; MUL only raises w_is_mul, the result comes later.
  always_comb begin
    w_a      = {1'b0, operand1};
    w_b      = {1'b0, operand2};
    w_sum    = w_a + w_b;
    w_dif    = w_a - w_b;
    w_res    = '0;
    w_ovf    = 1'b0;
    w_err    = 1'b0;
    w_is_mul = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                (w_sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                (w_dif[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_AND:  w_res = {1'b0, operand1 & operand2};
      OP_OR:   w_res = {1'b0, operand1 | operand2};
      OP_XOR:  w_res = {1'b0, operand1 ^ operand2};
      // Large shift amounts naturally shift everything out.
      OP_SLL:  w_res = w_a << operand2;
      OP_SRL:  w_res = {1'b0, operand1 >> operand2};
      OP_SRA:  w_res = {1'b0, $unsigned($signed(operand1) >>> operand2)};
      OP_SLT:  w_res = {{WIDTH{1'b0}}, ($signed(operand1) < $signed(operand2))};
      OP_SLTU: w_res = {{WIDTH{1'b0}}, (operand1 < operand2)};
      OP_MUL:  w_is_mul = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  // One shift-add step per cycle; the last step feeds the output register directly.
  always_comb begin
    w_pp       = r_mplier[r_cnt] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
    w_acc_nxt  = r_acc + w_pp;
    w_mul_done = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
  end

  // Handshake and output-register write selection.
  always_comb begin
    w_in_ready  = !reset && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    w_accept    = in_valid && w_in_ready;
    w_start_mul = w_accept && w_is_mul;
    w_wr        = (w_accept && !w_is_mul) || w_mul_done;
    w_wr_res    = w_res;
    w_wr_ovf    = w_ovf;
    w_wr_err    = w_err;
    if (w_mul_done) begin
      w_wr_res = {|w_acc_nxt[2*WIDTH-1:WIDTH], w_acc_nxt[WIDTH-1:0]};
      w_wr_ovf = 1'b0;
      w_wr_err = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: IDLE -> MUL on a MUL accept, back after the last bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier operand latch, accumulator and bit counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_start_mul) begin
      r_mcand  <= operand1;
      r_mplier <= operand2;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Output register: a write wins over a drain, otherwise hold while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_overflow  <= 1'b0;
      r_error     <= 1'b0;
    end else if (w_wr) begin
      r_out_valid <= 1'b1;
      r_result    <= w_wr_res;
      r_zero      <= ~|w_wr_res[WIDTH-1:0];
      r_negative  <= w_wr_res[WIDTH-1];
      r_overflow  <= w_wr_ovf;
      r_error     <= w_wr_err;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign overflow  = r_overflow;
  assign error     = r_error;

endmodule
